// File: rtl/activation_serializer_if.sv
// Handshake bundle between an activation layer, the serializer and the downstream consumer.
// The slave modport is the serializer side; the master modport is the producer/consumer side.
interface activation_serializer_if #(
    parameter int WIDTH = 10,
    parameter int SIZE  = 32
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data [SIZE];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic [IW-1:0]           out_index;
    logic                    out_last;
    logic                    frame_done;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, frame_done
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, frame_done
    );
endinterface

// File: rtl/activation_serializer.sv
// Captures a parallel activation vector and streams it out one element per accepted beat.
// state | meaning
// IDLE  | waiting for a vector; in_ready high, out_valid low
// SEND  | emitting buffered elements 0..SIZE-1 under out_ready backpressure
module activation_serializer #(
    parameter int WIDTH = 10,
    parameter int NFRAC = 5,
    parameter int SIZE  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    activation_serializer_if.slave bus
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    if (SIZE < 2) begin : g_size_chk
        $error("activation_serializer: SIZE must be at least 2");
    end
    if (NFRAC < 0 || NFRAC >= WIDTH) begin : g_nfrac_chk
        $error("activation_serializer: NFRAC must lie in [0, WIDTH)");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_next;
    logic signed [WIDTH-1:0] data_buf [SIZE];

    assign idx_next      = idx + IW'(1);
    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_index = idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_last   <= 1'b0;
            bus.frame_done <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_buf      <= bus.in_data;
                        idx           <= '0;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= bus.in_data[0];
                        bus.out_last  <= 1'b0;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (idx == LAST_IDX) begin
                            // Frame complete: drop back to IDLE and park the index at 0.
                            state          <= IDLE;
                            idx            <= '0;
                            bus.out_valid  <= 1'b0;
                            bus.out_data   <= '0;
                            bus.out_last   <= 1'b0;
                            bus.frame_done <= 1'b1;
                        end else begin
                            idx          <= idx_next;
                            bus.out_data <= data_buf[idx_next];
                            bus.out_last <= (idx_next == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
